// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - push-button channel bundle between board keys, key_conditioner and its consumer
interface key_conditioner_if #(
   parameter int NUM_KEYS = 3
);
   logic [NUM_KEYS-1:0] i_key_n;
   logic [NUM_KEYS-1:0] o_level;
   logic [NUM_KEYS-1:0] o_press;
   logic [NUM_KEYS-1:0] o_release;
   logic [NUM_KEYS-1:0] o_short;
   logic [NUM_KEYS-1:0] o_long;

   // consumer side: drives the raw keys, observes conditioned events
   modport master (
      output i_key_n,
      input  o_level,
      input  o_press,
      input  o_release,
      input  o_short,
      input  o_long
   );

   // conditioner side
   modport slave (
      input  i_key_n,
      output o_level,
      output o_press,
      output o_release,
      output o_short,
      output o_long
   );
endinterface

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - per-key synchronizer, debounce, press/release/short/long pulses; auto-repeat under KEY_AUTOREPEAT_EN
module key_conditioner #(
   parameter int NUM_KEYS        = 3,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000
) (
   input  logic             i_clk,
   input  logic             i_rst,
   key_conditioner_if.slave kif
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

`ifdef KEY_AUTOREPEAT_EN
   localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
`endif

   // Reject parameter sets the channel FSM cannot honour
   if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 2) begin : g_param_check
      $error("key_conditioner: illegal DEBOUNCE/LONG/REPEAT cycle parameters");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESS_DB,
      ST_HELD,
      ST_LONG_HELD,
      ST_RELEASE_DB
   } state_t;

   logic [NUM_KEYS-1:0] level_v;
   logic [NUM_KEYS-1:0] press_v;
   logic [NUM_KEYS-1:0] release_v;
   logic [NUM_KEYS-1:0] short_v;
   logic [NUM_KEYS-1:0] long_v;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      logic [1:0]        sync_q, sync_d;
      logic              s;
      state_t            state_q, state_d;
      logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
      logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
      logic [HOLD_W-1:0] hold_inc;
      logic              long_flag_q, long_flag_d;
      logic              level_q, level_d;
      logic              press_q, press_d;
      logic              release_q, release_d;
      logic              short_q, short_d;
      logic              long_q, long_d;
`ifdef KEY_AUTOREPEAT_EN
      logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
`endif

      // Two-stage synchronizer shift; stage 1 is the metastability catcher
      always_comb begin
         sync_d = {sync_q[0], kif.i_key_n[k]};
      end

      assign s = ~sync_q[1];

      // Hold counter advance, pinned at LONG_CYCLES so it never wraps
      always_comb begin
         hold_inc = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
      end

      // Channel FSM: debounce in both directions, hold timing, event pulses
      always_comb begin
         state_d     = state_q;
         db_cnt_d    = db_cnt_q;
         hold_cnt_d  = hold_cnt_q;
         long_flag_d = long_flag_q;
         level_d     = level_q;
         press_d     = 1'b0;
         release_d   = 1'b0;
         short_d     = 1'b0;
         long_d      = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
         rep_cnt_d   = rep_cnt_q;
`endif
         case (state_q)
            ST_IDLE: begin
               if (s) begin
                  state_d  = ST_PRESS_DB;
                  db_cnt_d = DB_W'(1);
               end
            end
            ST_PRESS_DB: begin
               if (!s) begin
                  state_d  = ST_IDLE;
                  db_cnt_d = '0;
               end else if (db_cnt_q == DB_LAST) begin
                  state_d    = ST_HELD;
                  db_cnt_d   = '0;
                  hold_cnt_d = '0;
                  level_d    = 1'b1;
                  press_d    = 1'b1;
               end else begin
                  db_cnt_d = db_cnt_q + DB_W'(1);
               end
            end
            ST_HELD: begin
               hold_cnt_d = hold_inc;
               // release beats the long threshold when both land together
               if (!s) begin
                  state_d     = ST_RELEASE_DB;
                  db_cnt_d    = DB_W'(1);
                  long_flag_d = 1'b0;
               end else if (hold_cnt_q >= LONG_LAST) begin
                  state_d = ST_LONG_HELD;
                  long_d  = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                  rep_cnt_d = '0;
`endif
               end
            end
            ST_LONG_HELD: begin
               hold_cnt_d = hold_inc;
               if (!s) begin
                  state_d     = ST_RELEASE_DB;
                  db_cnt_d    = DB_W'(1);
                  long_flag_d = 1'b1;
               end
`ifdef KEY_AUTOREPEAT_EN
               else if (rep_cnt_q == REP_LAST) begin
                  press_d   = 1'b1;
                  rep_cnt_d = '0;
               end else begin
                  rep_cnt_d = rep_cnt_q + REP_W'(1);
               end
`endif
            end
            ST_RELEASE_DB: begin
               // a bounce back to pressed resumes the hold without resetting timers
               if (s) begin
                  state_d  = long_flag_q ? ST_LONG_HELD : ST_HELD;
                  db_cnt_d = '0;
               end else if (db_cnt_q == DB_LAST) begin
                  state_d   = ST_IDLE;
                  db_cnt_d  = '0;
                  level_d   = 1'b0;
                  release_d = 1'b1;
                  short_d   = ~long_flag_q;
               end else begin
                  db_cnt_d = db_cnt_q + DB_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Channel state register; reset parks the key as released
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            sync_q      <= 2'b11;
            state_q     <= ST_IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_flag_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
`endif
         end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_flag_q <= long_flag_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            short_q     <= short_d;
            long_q      <= long_d;
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
`endif
         end
      end

      assign level_v[k]   = level_q;
      assign press_v[k]   = press_q;
      assign release_v[k] = release_q;
      assign short_v[k]   = short_q;
      assign long_v[k]    = long_q;
   end

   assign kif.o_level   = level_v;
   assign kif.o_press   = press_v;
   assign kif.o_release = release_v;
   assign kif.o_short   = short_v;
   assign kif.o_long    = long_v;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed-vector bench for key_conditioner (DEBOUNCE=4, LONG=20, REPEAT=5)
module tb_key_conditioner;

   localparam int EV_PRESS   = 0;
   localparam int EV_RELEASE = 1;
   localparam int EV_SHORT   = 2;
   localparam int EV_LONG    = 3;

   typedef struct {
      int cyc;
      int kind;
      int key;
   } ev_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_vec;
   int   n_err;
   int   n_overlap;
   int   n_wide;
   ev_t  evq[$];

   logic [2:0] prev_rel, prev_short, prev_long;

   key_conditioner_if #(.NUM_KEYS(3)) kif ();

   key_conditioner #(
      .NUM_KEYS(3),
      .DEBOUNCE_CYCLES(4),
      .LONG_CYCLES(20),
      .REPEAT_CYCLES(5)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .kif(kif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event log sampled on the falling edge
   initial begin
      n_overlap  = 0;
      n_wide     = 0;
      prev_rel   = '0;
      prev_short = '0;
      prev_long  = '0;
   end
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (kif.o_press[k])   evq.push_back('{cyc, EV_PRESS, k});
         if (kif.o_release[k]) evq.push_back('{cyc, EV_RELEASE, k});
         if (kif.o_short[k])   evq.push_back('{cyc, EV_SHORT, k});
         if (kif.o_long[k])    evq.push_back('{cyc, EV_LONG, k});
      end
      if ((kif.o_press & kif.o_release) != 3'b000) n_overlap = n_overlap + 1;
      if ((kif.o_release & prev_rel) != 3'b000)     n_wide = n_wide + 1;
      if ((kif.o_short & prev_short) != 3'b000)     n_wide = n_wide + 1;
      if ((kif.o_long & prev_long) != 3'b000)       n_wide = n_wide + 1;
      prev_rel   = kif.o_release;
      prev_short = kif.o_short;
      prev_long  = kif.o_long;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int count_ev(input int kind, input int key, input int lo, input int hi);
      int n;
      n = 0;
      foreach (evq[i])
         if (evq[i].kind == kind && evq[i].key == key && evq[i].cyc >= lo && evq[i].cyc <= hi)
            n++;
      return n;
   endfunction

   function automatic int first_ev(input int kind, input int key, input int lo);
      foreach (evq[i])
         if (evq[i].kind == kind && evq[i].key == key && evq[i].cyc >= lo)
            return evq[i].cyc;
      return -1;
   endfunction

   function automatic int any_ev(input int key, input int lo, input int hi);
      return count_ev(EV_PRESS, key, lo, hi) + count_ev(EV_RELEASE, key, lo, hi) +
             count_ev(EV_SHORT, key, lo, hi) + count_ev(EV_LONG, key, lo, hi);
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int all_outs();
      return int'({kif.o_level, kif.o_press, kif.o_release, kif.o_short, kif.o_long});
   endfunction

   int n0, m0;

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      kif.i_key_n = 3'b111;
      step(3);
      check("reset_outputs", all_outs(), 0);
      rst = 1'b0;
      step(2);
      check("idle_outputs", all_outs(), 0);

      // key0 short press: 15 cycles low
      n0 = cyc;
      kif.i_key_n = 3'b110;
      step(5);
      check("k0_level_pre", int'(kif.o_level[0]), 0);
      step(1);
      check("k0_level_post", int'(kif.o_level[0]), 1);
      step(9);
      kif.i_key_n = 3'b111;
      step(10);
      check("k0_press_at", first_ev(EV_PRESS, 0, n0), n0 + 6);
      check("k0_press_cnt", count_ev(EV_PRESS, 0, n0, cyc), 1);
      check("k0_release_at", first_ev(EV_RELEASE, 0, n0), n0 + 21);
      check("k0_short_at", first_ev(EV_SHORT, 0, n0), n0 + 21);
      check("k0_no_long", count_ev(EV_LONG, 0, n0, cyc), 0);
      check("k12_quiet", any_ev(1, n0, cyc) + any_ev(2, n0, cyc), 0);
      check("k0_level_end", int'(kif.o_level[0]), 0);

      // key1 3-cycle glitch rejected
      n0 = cyc;
      kif.i_key_n = 3'b101;
      step(3);
      kif.i_key_n = 3'b111;
      step(12);
      check("glitch_no_events", any_ev(0, n0, cyc) + any_ev(1, n0, cyc) + any_ev(2, n0, cyc), 0);
      check("glitch_level", int'(kif.o_level), 0);

      // key1 4-cycle pulse is the shortest accepted press
      n0 = cyc;
      kif.i_key_n = 3'b101;
      step(4);
      kif.i_key_n = 3'b111;
      step(12);
      check("k1_min_press_at", first_ev(EV_PRESS, 1, n0), n0 + 6);
      check("k1_min_release_at", first_ev(EV_RELEASE, 1, n0), n0 + 10);
      check("k1_min_short_at", first_ev(EV_SHORT, 1, n0), n0 + 10);

      // key2 long hold: 40 cycles
      n0 = cyc;
      kif.i_key_n = 3'b011;
      step(40);
      kif.i_key_n = 3'b111;
      step(12);
      check("k2_press_at", first_ev(EV_PRESS, 2, n0), n0 + 6);
      check("k2_long_at", first_ev(EV_LONG, 2, n0), n0 + 26);
      check("k2_long_cnt", count_ev(EV_LONG, 2, n0, cyc), 1);
      check("k2_release_at", first_ev(EV_RELEASE, 2, n0), n0 + 46);
      check("k2_no_short", count_ev(EV_SHORT, 2, n0, cyc), 0);
`ifdef KEY_AUTOREPEAT_EN
      check("k2_press_cnt", count_ev(EV_PRESS, 2, n0, cyc), 4);
      check("k2_repeat1_at", first_ev(EV_PRESS, 2, n0 + 7), n0 + 31);
      check("k2_repeat2_at", first_ev(EV_PRESS, 2, n0 + 32), n0 + 36);
`else
      check("k2_press_cnt", count_ev(EV_PRESS, 2, n0, cyc), 1);
`endif

      // key0 held with a 2-cycle release bounce; hold time keeps accumulating
      n0 = cyc;
      kif.i_key_n = 3'b110;
      step(16);
      kif.i_key_n = 3'b111;
      step(2);
      kif.i_key_n = 3'b110;
      step(22);
      kif.i_key_n = 3'b111;
      step(12);
      check("bounce_press_at", first_ev(EV_PRESS, 0, n0), n0 + 6);
      check("bounce_no_early_rel", count_ev(EV_RELEASE, 0, n0, n0 + 45), 0);
      check("bounce_long_at", first_ev(EV_LONG, 0, n0), n0 + 28);
      check("bounce_release_at", first_ev(EV_RELEASE, 0, n0), n0 + 46);
      check("bounce_no_short", count_ev(EV_SHORT, 0, n0, cyc), 0);
`ifdef KEY_AUTOREPEAT_EN
      check("bounce_press_cnt", count_ev(EV_PRESS, 0, n0, cyc), 3);
`else
      check("bounce_press_cnt", count_ev(EV_PRESS, 0, n0, cyc), 1);
`endif

      // all three keys together
      n0 = cyc;
      kif.i_key_n = 3'b000;
      step(10);
      kif.i_key_n = 3'b111;
      step(12);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("all_press_at_%0d", k), first_ev(EV_PRESS, k, n0), n0 + 6);
         check($sformatf("all_release_at_%0d", k), first_ev(EV_RELEASE, k, n0), n0 + 16);
         check($sformatf("all_short_at_%0d", k), first_ev(EV_SHORT, k, n0), n0 + 16);
      end

      // reset mid-hold on key1 while it stays pressed
      n0 = cyc;
      kif.i_key_n = 3'b101;
      step(10);
      check("rst_mid_level_before", int'(kif.o_level[1]), 1);
      rst = 1'b1;
      #1;
      check("rst_mid_outputs", all_outs(), 0);
      step(2);
      rst = 1'b0;
      m0 = cyc;
      step(8);
      check("rst_no_early_press", count_ev(EV_PRESS, 1, n0 + 7, m0 + 5), 0);
      check("rst_repress_at", first_ev(EV_PRESS, 1, m0), m0 + 6);
      check("rst_repress_level", int'(kif.o_level[1]), 1);
      kif.i_key_n = 3'b111;
      step(12);
      check("rst_release_at", first_ev(EV_RELEASE, 1, m0), m0 + 14);

      check("press_release_overlap", n_overlap, 0);
      check("pulse_wider_than_one", n_wide, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
